pattern_eval_scheduler: RTL and testbench

Sequences the pattern evaluator over a bank of candidate juggling patterns for each captured frame of detected ball positions. Per frame: latches real ball positions, fetches each candidate's model positions from the model source, resets and launches the evaluator, collects its error, and reports the lowest-error candidate. Sits between the ball tracker / model generator and the Hungarian-matching evaluator, upstream of the display and scoring logic.

---
 rtl/pattern_eval_scheduler_if.sv | 58 +++++
 rtl/pattern_eval_scheduler.sv | 160 ++++++++++++++++
 tb/tb_pattern_eval_scheduler.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pattern_eval_scheduler_if.sv
// Signal bundle between the pattern-evaluation scheduler, the model source,
// the Hungarian-matching evaluator and the downstream result consumers.
interface pattern_eval_scheduler_if #(
  parameter int NUM_CANDIDATES = 8,
  parameter int CAND_W         = $clog2(NUM_CANDIDATES)
);
  logic                     frame_valid_in;
  logic [2:0]               num_balls_in;
  logic [10:0]              real_balls_x_in  [6:0];
  logic [9:0]               real_balls_y_in  [6:0];

  logic                     model_req_out;
  logic [CAND_W-1:0]        model_index_out;
  logic                     model_valid_in;
  logic [10:0]              model_balls_x_in [6:0];
  logic [9:0]               model_balls_y_in [6:0];

  logic                     eval_rst_out;
  logic                     eval_valid_out;
  logic [2:0]               eval_num_balls_out;
  logic [10:0]              eval_model_x_out [6:0];
  logic [9:0]               eval_model_y_out [6:0];
  logic [10:0]              eval_real_x_out  [6:0];
  logic [9:0]               eval_real_y_out  [6:0];
  logic                     eval_valid_in;
  logic signed [14:0]       eval_error_in;
  logic                     eval_correct_in;

  logic                     busy_out;
  logic                     result_valid_out;
  logic [CAND_W-1:0]        best_index_out;
  logic signed [14:0]       best_error_out;
  logic                     best_correct_out;
  logic                     timeout_out;
  logic                     frame_dropped_out;

  modport slave (
    input  frame_valid_in, num_balls_in, real_balls_x_in, real_balls_y_in,
    input  model_valid_in, model_balls_x_in, model_balls_y_in,
    input  eval_valid_in, eval_error_in, eval_correct_in,
    output model_req_out, model_index_out,
    output eval_rst_out, eval_valid_out, eval_num_balls_out,
    output eval_model_x_out, eval_model_y_out, eval_real_x_out, eval_real_y_out,
    output busy_out, result_valid_out, best_index_out, best_error_out,
    output best_correct_out, timeout_out, frame_dropped_out
  );

  modport master (
    output frame_valid_in, num_balls_in, real_balls_x_in, real_balls_y_in,
    output model_valid_in, model_balls_x_in, model_balls_y_in,
    output eval_valid_in, eval_error_in, eval_correct_in,
    input  model_req_out, model_index_out,
    input  eval_rst_out, eval_valid_out, eval_num_balls_out,
    input  eval_model_x_out, eval_model_y_out, eval_real_x_out, eval_real_y_out,
    input  busy_out, result_valid_out, best_index_out, best_error_out,
    input  best_correct_out, timeout_out, frame_dropped_out
  );
endinterface

// File: rtl/pattern_eval_scheduler.sv
// Per captured frame, runs the pattern evaluator over every candidate model
// and reports the lowest-error candidate with its verdict.
module pattern_eval_scheduler #(
  parameter int NUM_CANDIDATES = 8,
  parameter int TIMEOUT        = 4096,
  parameter int CAND_W         = $clog2(NUM_CANDIDATES)
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  pattern_eval_scheduler_if.slave sched
);
  localparam int                 WAIT_W    = $clog2(TIMEOUT);
  localparam logic [WAIT_W-1:0]  WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam logic [CAND_W-1:0]  CAND_LAST = CAND_W'(NUM_CANDIDATES - 1);
  localparam logic signed [14:0] ERR_MAX   = 15'sh3FFF;

  typedef enum logic [2:0] {
    IDLE, FETCH, EVAL_RST, EVAL_START, EVAL_WAIT, UPDATE, DONE
  } state_t;

  state_t state, state_nxt;

  logic [1:0]         rst_sync;
  logic               rst_int_n;
  logic [CAND_W-1:0]  cand;
  logic [WAIT_W-1:0]  wait_cnt;
  logic [2:0]         nb_q;
  logic [10:0]        real_x_q  [6:0];
  logic [9:0]         real_y_q  [6:0];
  logic [10:0]        model_x_q [6:0];
  logic [9:0]         model_y_q [6:0];
  logic signed [14:0] cap_err, best_err;
  logic               cap_corr, best_corr;
  logic [CAND_W-1:0]  best_idx;
  logic               timeout_q, dropped_q;
  logic               model_req, eval_rst_st, eval_start, result_valid, busy;
  logic               frame_accept, wait_expired;

  // Assert asynchronously, release two edges after rst_n_in rises.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) rst_sync <= '0;
    else           rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_int_n = rst_sync[1];

  assign frame_accept = (state == IDLE) && sched.frame_valid_in && (sched.num_balls_in != 3'd0);
  assign wait_expired = (wait_cnt == WAIT_LAST);

  always_ff @(posedge clk_in or negedge rst_int_n) begin
    if (!rst_int_n) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if (frame_accept) state_nxt = FETCH;
      FETCH:      if (sched.model_valid_in) state_nxt = EVAL_RST;
      EVAL_RST:   state_nxt = EVAL_START;
      EVAL_START: state_nxt = EVAL_WAIT;
      EVAL_WAIT:  if (sched.eval_valid_in || wait_expired) state_nxt = UPDATE;
      UPDATE:     state_nxt = (cand == CAND_LAST) ? DONE : FETCH;
      DONE:       state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    model_req    = 1'b0;
    eval_rst_st  = 1'b0;
    eval_start   = 1'b0;
    result_valid = 1'b0;
    busy         = 1'b1;
    case (state)
      IDLE:       busy         = 1'b0;
      FETCH:      model_req    = 1'b1;
      EVAL_RST:   eval_rst_st  = 1'b1;
      EVAL_START: eval_start   = 1'b1;
      DONE:       result_valid = 1'b1;
      default:    ;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_int_n) begin
    if (!rst_int_n) begin
      cand      <= '0;
      wait_cnt  <= '0;
      nb_q      <= '0;
      real_x_q  <= '{default: '0};
      real_y_q  <= '{default: '0};
      model_x_q <= '{default: '0};
      model_y_q <= '{default: '0};
      cap_err   <= ERR_MAX;
      cap_corr  <= 1'b0;
      best_err  <= ERR_MAX;
      best_corr <= 1'b0;
      best_idx  <= '0;
      timeout_q <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      // A frame arriving while busy is dropped; one with no balls is too.
      dropped_q <= sched.frame_valid_in && ((state != IDLE) || (sched.num_balls_in == 3'd0));
      case (state)
        IDLE: if (frame_accept) begin
          nb_q      <= sched.num_balls_in;
          real_x_q  <= sched.real_balls_x_in;
          real_y_q  <= sched.real_balls_y_in;
          cand      <= '0;
          best_err  <= ERR_MAX;
          best_idx  <= '0;
          best_corr <= 1'b0;
          timeout_q <= 1'b0;
        end
        FETCH: if (sched.model_valid_in) begin
          model_x_q <= sched.model_balls_x_in;
          model_y_q <= sched.model_balls_y_in;
        end
        EVAL_START: wait_cnt <= '0;
        EVAL_WAIT: begin
          wait_cnt <= wait_cnt + 1'b1;
          if (sched.eval_valid_in) begin
            cap_err  <= sched.eval_error_in;
            cap_corr <= sched.eval_correct_in;
          end else if (wait_expired) begin
            cap_err   <= ERR_MAX;
            cap_corr  <= 1'b0;
            timeout_q <= 1'b1;
          end
        end
        UPDATE: begin
          // Strict less-than: on a tie the earlier candidate is kept.
          if (cap_err < best_err) begin
            best_err  <= cap_err;
            best_idx  <= cand;
            best_corr <= cap_corr;
          end
          if (cand != CAND_LAST) cand <= cand + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign sched.model_req_out      = model_req;
  assign sched.model_index_out    = cand;
  assign sched.eval_rst_out       = ~rst_n_in | eval_rst_st;
  assign sched.eval_valid_out     = eval_start;
  assign sched.eval_num_balls_out = nb_q;
  assign sched.eval_model_x_out   = model_x_q;
  assign sched.eval_model_y_out   = model_y_q;
  assign sched.eval_real_x_out    = real_x_q;
  assign sched.eval_real_y_out    = real_y_q;
  assign sched.busy_out           = busy;
  assign sched.result_valid_out   = result_valid;
  assign sched.best_index_out     = best_idx;
  assign sched.best_error_out     = best_err;
  assign sched.best_correct_out   = best_corr;
  assign sched.timeout_out        = timeout_q;
  assign sched.frame_dropped_out  = dropped_q;
endmodule

// File: tb/tb_pattern_eval_scheduler.sv
// Directed bench: model source with fixed latency, evaluator stub with per-candidate
// error table, and a monitor for strobe ordering and array stability.
module tb_pattern_eval_scheduler;
  localparam int NC = 4;
  localparam int TO = 64;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pattern_eval_scheduler_if #(.NUM_CANDIDATES(NC)) bus ();

  pattern_eval_scheduler #(.NUM_CANDIDATES(NC), .TIMEOUT(TO)) dut (
    .clk_in   (clk),
    .rst_n_in (rst_n),
    .sched    (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  logic signed [14:0] err_tbl  [NC];
  logic               corr_tbl [NC];
  int                 hang_idx = -1;
  int                 ev_lat   = 3;

  int busy_cycles, res_pulses, drop_pulses, rst_pulses, start_pulses, seq_err, arr_err;
  int idx_log [$];
  logic [10:0] exp_rx [7];
  logic [9:0]  exp_ry [7];
  logic [2:0]  exp_nb;

  function automatic logic [10:0] mx(input int idx, input int i);
    return 11'(idx * 100 + i * 7 + 5);
  endfunction
  function automatic logic [9:0] my(input int idx, input int i);
    return 10'(idx * 40 + i * 3 + 2);
  endfunction

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    busy_cycles = 0; res_pulses = 0; drop_pulses = 0;
    rst_pulses = 0; start_pulses = 0; seq_err = 0; arr_err = 0;
    idx_log.delete();
  endtask

  task automatic set_tables(input int e0, input int e1, input int e2, input int e3,
                            input logic [3:0] corr);
    err_tbl[0] = 15'(e0); err_tbl[1] = 15'(e1); err_tbl[2] = 15'(e2); err_tbl[3] = 15'(e3);
    for (int i = 0; i < NC; i++) corr_tbl[i] = corr[i];
  endtask

  task automatic send_frame(input logic [2:0] nb, input int seed);
    for (int i = 0; i < 7; i++) begin
      exp_rx[i] = 11'(seed * 37 + i * 19);
      exp_ry[i] = 10'(seed * 23 + i * 11);
      bus.real_balls_x_in[i] = exp_rx[i];
      bus.real_balls_y_in[i] = exp_ry[i];
    end
    exp_nb = nb;
    bus.num_balls_in   = nb;
    bus.frame_valid_in = 1'b1;
    @(negedge clk);
    bus.frame_valid_in = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int bound);
    int n;
    n = 0;
    while (bus.busy_out && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(bus.busy_out), 0);
    @(negedge clk);
  endtask

  task automatic check_idx_walk(input string tag);
    chk({tag, "_idx_n"}, idx_log.size(), NC);
    for (int i = 0; i < NC; i++)
      chk({tag, "_idx"}, (i < idx_log.size()) ? idx_log[i] : -1, i);
  endtask

  // Model source: answers a request on its second cycle.
  initial begin
    int mcnt;
    mcnt = 0;
    bus.model_valid_in = 1'b0;
    for (int i = 0; i < 7; i++) begin
      bus.model_balls_x_in[i] = '0;
      bus.model_balls_y_in[i] = '0;
    end
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bus.model_valid_in = 1'b0; mcnt = 0;
      end else if (bus.model_valid_in) begin
        bus.model_valid_in = 1'b0; mcnt = 0;
      end else if (bus.model_req_out) begin
        mcnt++;
        if (mcnt == 2) begin
          for (int i = 0; i < 7; i++) begin
            bus.model_balls_x_in[i] = mx(int'(bus.model_index_out), i);
            bus.model_balls_y_in[i] = my(int'(bus.model_index_out), i);
          end
          bus.model_valid_in = 1'b1;
        end
      end
    end
  end

  // Evaluator stub: valid is a level, cleared by its reset.
  initial begin
    int  ecnt;
    int  eidx;
    bit  armed;
    ecnt = 0; eidx = 0; armed = 1'b0;
    bus.eval_valid_in   = 1'b0;
    bus.eval_error_in   = '0;
    bus.eval_correct_in = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.eval_rst_out) begin
        bus.eval_valid_in = 1'b0; armed = 1'b0; ecnt = 0;
      end else if (bus.eval_valid_out) begin
        armed = 1'b1; ecnt = 0; eidx = int'(bus.model_index_out);
      end else if (armed) begin
        ecnt++;
        if (ecnt == ev_lat && eidx != hang_idx) begin
          bus.eval_valid_in   = 1'b1;
          bus.eval_error_in   = err_tbl[eidx];
          bus.eval_correct_in = corr_tbl[eidx];
          armed = 1'b0;
        end
      end
    end
  end

  // Monitor: strobe order, index walk, array contents and stability.
  initial begin
    logic        prev_rst, prev_start;
    logic [10:0] sx [7];
    logic [9:0]  sy [7];
    logic [10:0] srx [7];
    logic [9:0]  sry [7];
    logic [2:0]  snb;
    prev_rst = 1'b0; prev_start = 1'b0; snb = '0;
    for (int i = 0; i < 7; i++) begin sx[i] = '0; sy[i] = '0; srx[i] = '0; sry[i] = '0; end
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        prev_rst = 1'b0; prev_start = 1'b0;
      end else begin
        if (bus.busy_out)          busy_cycles++;
        if (bus.result_valid_out)  res_pulses++;
        if (bus.frame_dropped_out) drop_pulses++;
        if (bus.model_valid_in && bus.model_req_out) idx_log.push_back(int'(bus.model_index_out));
        if (bus.eval_rst_out) begin
          rst_pulses++;
          if (prev_rst) seq_err++;
          for (int i = 0; i < 7; i++) begin
            sx[i] = bus.eval_model_x_out[i]; sy[i] = bus.eval_model_y_out[i];
            srx[i] = bus.eval_real_x_out[i]; sry[i] = bus.eval_real_y_out[i];
          end
          snb = bus.eval_num_balls_out;
        end
        if (prev_rst && !bus.eval_valid_out) seq_err++;
        if (bus.eval_valid_out) begin
          start_pulses++;
          if (!prev_rst || prev_start || bus.eval_rst_out) seq_err++;
          if (bus.eval_num_balls_out !== exp_nb) arr_err++;
          for (int i = 0; i < 7; i++) begin
            if (bus.eval_model_x_out[i] !== mx(int'(bus.model_index_out), i)) arr_err++;
            if (bus.eval_model_y_out[i] !== my(int'(bus.model_index_out), i)) arr_err++;
            if (bus.eval_real_x_out[i] !== exp_rx[i]) arr_err++;
            if (bus.eval_real_y_out[i] !== exp_ry[i]) arr_err++;
          end
        end
        if (bus.busy_out && !bus.model_req_out && !bus.eval_rst_out) begin
          if (bus.eval_num_balls_out !== snb) arr_err++;
          for (int i = 0; i < 7; i++) begin
            if (bus.eval_model_x_out[i] !== sx[i] || bus.eval_model_y_out[i] !== sy[i]) arr_err++;
            if (bus.eval_real_x_out[i] !== srx[i] || bus.eval_real_y_out[i] !== sry[i]) arr_err++;
          end
        end
        prev_rst   = bus.eval_rst_out;
        prev_start = bus.eval_valid_out;
      end
    end
  end

  initial begin
    bit found;
    bus.frame_valid_in = 1'b0;
    bus.num_balls_in   = '0;
    for (int i = 0; i < 7; i++) begin
      bus.real_balls_x_in[i] = '0;
      bus.real_balls_y_in[i] = '0;
      exp_rx[i] = '0; exp_ry[i] = '0;
    end
    exp_nb = '0;
    set_tables(0, 0, 0, 0, 4'b0000);
    clear_stats();

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_eval_rst",     32'(bus.eval_rst_out), 1);
    chk("rst_best_err",     32'(bus.best_error_out), 16383);
    chk("rst_busy",         32'(bus.busy_out), 0);
    chk("rst_model_req",    32'(bus.model_req_out), 0);
    chk("rst_eval_valid",   32'(bus.eval_valid_out), 0);
    chk("rst_result_valid", 32'(bus.result_valid_out), 0);
    chk("rst_timeout",      32'(bus.timeout_out), 0);
    chk("rst_real_x0",      32'(bus.eval_real_x_out[0]), 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("rel_eval_rst",  32'(bus.eval_rst_out), 0);
    chk("rel_busy",      32'(bus.busy_out), 0);
    chk("rel_best_idx",  32'(bus.best_index_out), 0);
    chk("rel_dropped",   32'(bus.frame_dropped_out), 0);

    // Frame 1: errors 900,300,300,700 -> tie keeps index 1; nothing correct
    set_tables(900, 300, 300, 700, 4'b0000);
    hang_idx = -1; ev_lat = 3;
    clear_stats();
    send_frame(3'd3, 1);
    wait_idle("f1_done", 400);
    chk("f1_results",     res_pulses, 1);
    chk("f1_best_idx",    32'(bus.best_index_out), 1);
    chk("f1_best_err",    32'(bus.best_error_out), 300);
    chk("f1_best_corr",   32'(bus.best_correct_out), 0);
    chk("f1_timeout",     32'(bus.timeout_out), 0);
    chk("f1_busy_cycles", busy_cycles, 33);
    chk("f1_rst_pulses",  rst_pulses, NC);
    chk("f1_start_pulses", start_pulses, NC);
    chk("f1_seq",         seq_err, 0);
    chk("f1_arrays",      arr_err, 0);
    check_idx_walk("f1");
    repeat (3) @(negedge clk);
    chk("f1_hold_idx", 32'(bus.best_index_out), 1);
    chk("f1_hold_err", 32'(bus.best_error_out), 300);

    // Frame 2: negative error wins and is correct; a frame arriving mid-run is dropped
    set_tables(500, -20, 600, 400, 4'b0010);
    clear_stats();
    send_frame(3'd5, 2);
    repeat (6) @(negedge clk);
    bus.num_balls_in       = 3'd4;
    bus.real_balls_x_in[0] = 11'h7FF;
    bus.frame_valid_in     = 1'b1;
    @(negedge clk);
    bus.frame_valid_in = 1'b0;
    chk("busy_drop_pulse", 32'(bus.frame_dropped_out), 1);
    chk("busy_drop_busy",  32'(bus.busy_out), 1);
    @(negedge clk);
    chk("busy_drop_once",  32'(bus.frame_dropped_out), 0);
    wait_idle("f2_done", 400);
    chk("f2_results",     res_pulses, 1);
    chk("f2_drops",       drop_pulses, 1);
    chk("f2_best_idx",    32'(bus.best_index_out), 1);
    chk("f2_best_err",    32'(bus.best_error_out), -20);
    chk("f2_best_corr",   32'(bus.best_correct_out), 1);
    chk("f2_busy_cycles", busy_cycles, 33);
    chk("f2_seq",         seq_err, 0);
    chk("f2_arrays",      arr_err, 0);

    // Frame 3: candidate 2 never answers; its table entry would otherwise win
    set_tables(800, 600, 100, 700, 4'b0100);
    hang_idx = 2; ev_lat = 2;
    clear_stats();
    send_frame(3'd7, 3);
    wait_idle("f3_done", 400);
    chk("f3_results",     res_pulses, 1);
    chk("f3_best_idx",    32'(bus.best_index_out), 1);
    chk("f3_best_err",    32'(bus.best_error_out), 600);
    chk("f3_best_corr",   32'(bus.best_correct_out), 0);
    chk("f3_timeout",     32'(bus.timeout_out), 1);
    chk("f3_busy_cycles", busy_cycles, 91);
    chk("f3_seq",         seq_err, 0);

    // Zero-ball frame while idle
    clear_stats();
    bus.num_balls_in   = 3'd0;
    bus.frame_valid_in = 1'b1;
    @(negedge clk);
    bus.frame_valid_in = 1'b0;
    chk("zero_drop_pulse", 32'(bus.frame_dropped_out), 1);
    chk("zero_busy",       32'(bus.busy_out), 0);
    @(negedge clk);
    chk("zero_busy_after", 32'(bus.busy_out), 0);
    chk("zero_drop_once",  32'(bus.frame_dropped_out), 0);
    chk("zero_timeout_hold", 32'(bus.timeout_out), 1);

    // Frame 4: timeout flag clears at frame start; last candidate wins correctly
    set_tables(100, 200, 300, 50, 4'b1000);
    hang_idx = -1; ev_lat = 3;
    clear_stats();
    send_frame(3'd1, 4);
    wait_idle("f4_done", 400);
    chk("f4_results",   res_pulses, 1);
    chk("f4_best_idx",  32'(bus.best_index_out), 3);
    chk("f4_best_err",  32'(bus.best_error_out), 50);
    chk("f4_best_corr", 32'(bus.best_correct_out), 1);
    chk("f4_timeout",   32'(bus.timeout_out), 0);

    // Reset during candidate 1's evaluation wait
    clear_stats();
    send_frame(3'd2, 5);
    found = 1'b0;
    for (int n = 0; n < 100 && !found; n++) begin
      if (bus.busy_out && bus.model_index_out == 2'd1 && !bus.model_req_out &&
          !bus.eval_rst_out && !bus.eval_valid_out)
        found = 1'b1;
      else
        @(negedge clk);
    end
    chk("mr_reach_wait", 32'(found), 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mr_busy",      32'(bus.busy_out), 0);
    chk("mr_eval_rst",  32'(bus.eval_rst_out), 1);
    chk("mr_best_err",  32'(bus.best_error_out), 16383);
    chk("mr_index",     32'(bus.model_index_out), 0);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("mr_no_result", res_pulses, 0);
    chk("mr_idle",      32'(bus.busy_out), 0);

    // Frame 5 after the reset restarts from candidate 0
    clear_stats();
    send_frame(3'd6, 6);
    wait_idle("f5_done", 400);
    chk("f5_results",  res_pulses, 1);
    chk("f5_best_idx", 32'(bus.best_index_out), 3);
    chk("f5_best_err", 32'(bus.best_error_out), 50);
    chk("f5_arrays",   arr_err, 0);
    check_idx_walk("f5");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
